// File: rtl/cpsr_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : cpsr_ctrl_pkg
// Description : Shared definitions for the CPSR write controller: field-load
//               codes, CPSR field bit ranges and the sequencer state type.
// Revision    : 1.0 - initial release
//============================================================================
package cpsr_ctrl_pkg;

    // Field-load codes presented to the CPSR
    localparam logic [2:0] LD_HOLD  = 3'b000;
    localparam logic [2:0] LD_CTRL  = 3'b001;
    localparam logic [2:0] LD_MODE  = 3'b010;
    localparam logic [2:0] LD_FLAGS = 3'b100;
    localparam logic [2:0] LD_ALL   = 3'b111;

    // CPSR field bit ranges
    localparam int FLAGS_HI = 31;
    localparam int FLAGS_LO = 28;
    localparam int UPPER_HI = 31;
    localparam int UPPER_LO = 10;
    localparam int CTRL_HI  = 9;
    localparam int CTRL_LO  = 6;
    localparam int MODE_HI  = 5;
    localparam int MODE_LO  = 0;

    // Sequencer states
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_EXC_SET = 1'b1
    } state_t;

endpackage : cpsr_ctrl_pkg
`default_nettype wire

// File: rtl/cpsr_ctrl_spsr_stack.sv
`default_nettype none
//============================================================================
// Module      : spsr_stack
// Description : LIFO of saved CPSR values for nested exceptions. top shows
//               the entry at level-1, or zero when the stack is empty.
// Revision    : 1.0 - initial release
//============================================================================
module spsr_stack #(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   din,
    output logic [31:0]   top,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int            IW        = $clog2(DEPTH);
    localparam logic [LW-1:0] c_one_lvl = LW'(1);
    localparam logic [IW-1:0] c_one_idx = IW'(1);
    localparam logic [LW-1:0] c_full    = LW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [LW-1:0] r_level;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;

    // Low index bits suffice: a push only happens below DEPTH, and at
    // level==DEPTH the low bits wrap to DEPTH-1 when decremented.
    assign w_wr_idx  = r_level[IW-1:0];
    assign w_top_idx = r_level[IW-1:0] - c_one_idx;

    assign level = r_level;
    assign full  = (r_level == c_full);
    assign empty = (r_level == '0);
    assign top   = empty ? 32'h0 : r_mem[w_top_idx];

    // Storage and occupancy; push is ignored when full, pop when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= din;
            r_level         <= r_level + c_one_lvl;
        end else if (pop && !empty) begin
            r_level <= r_level - c_one_lvl;
        end
    end

endmodule : spsr_stack
`default_nettype wire

// File: rtl/cpsr_ctrl.sv
`default_nettype none
//============================================================================
// Module      : cpsr_ctrl
// Description : Fixed-priority arbiter and sequencer owning all CPSR writes
//               (exception entry > exception return > MSR > ALU flags),
//               with an SPSR stack for nested exceptions.
// Revision    : 1.0 - initial release
//============================================================================
module cpsr_ctrl
    import cpsr_ctrl_pkg::*;
#(
    parameter  int         DEPTH     = 4,
    parameter  logic [3:0] EXC_IMASK = 4'b0011,
    localparam int         LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   cpsr_q,
    output logic [2:0]    cpsr_ld,
    output logic [31:0]   cpsr_din,
    input  logic          exc_req,
    input  logic [5:0]    exc_mode,
    output logic          exc_ack,
    output logic          exc_ovf,
    input  logic          ret_req,
    output logic          ret_ack,
    output logic          ret_err,
    input  logic          msr_req,
    input  logic [2:0]    msr_mask,
    input  logic [31:0]   msr_data,
    output logic          msr_ack,
    input  logic          flag_req,
    input  logic [3:0]    flag_nzcv,
    output logic          flag_ack,
    output logic [31:0]   spsr_q,
    output logic [LW-1:0] spsr_lvl,
    output logic          busy
);

    state_t      r_state;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_top;

    spsr_stack #(
        .DEPTH (DEPTH)
    ) u_spsr_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (cpsr_q),
        .top   (w_top),
        .level (spsr_lvl),
        .full  (w_full),
        .empty (w_empty)
    );

    assign spsr_q = w_top;
    assign busy   = (r_state != ST_IDLE);

    // Grant arbitration and CPSR write decode for the current state
    always_comb begin
        cpsr_ld  = LD_HOLD;
        cpsr_din = 32'h0;
        exc_ack  = 1'b0;
        exc_ovf  = 1'b0;
        ret_ack  = 1'b0;
        ret_err  = 1'b0;
        msr_ack  = 1'b0;
        flag_ack = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (r_state == ST_EXC_SET) begin
            // Second half of entry: mask interrupts and switch mode
            cpsr_ld  = LD_ALL;
            cpsr_din = {cpsr_q[UPPER_HI:UPPER_LO],
                        cpsr_q[CTRL_HI:CTRL_LO] | EXC_IMASK,
                        exc_mode[MODE_HI:MODE_LO]};
            exc_ack  = 1'b1;
        end else if (exc_req) begin
            if (w_full) begin
                exc_ack = 1'b1;
                exc_ovf = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (ret_req) begin
            ret_ack = 1'b1;
            if (w_empty) begin
                ret_err = 1'b1;
            end else begin
                cpsr_ld  = LD_ALL;
                cpsr_din = w_top;
                w_pop    = 1'b1;
            end
        end else if (msr_req) begin
            msr_ack = 1'b1;
            if (msr_mask == LD_CTRL || msr_mask == LD_MODE ||
                msr_mask == LD_FLAGS || msr_mask == LD_ALL) begin
                cpsr_ld  = msr_mask;
                cpsr_din = msr_data;
            end
        end else if (flag_req) begin
            flag_ack = 1'b1;
            cpsr_ld  = LD_FLAGS;
            cpsr_din = {flag_nzcv, cpsr_q[FLAGS_LO-1:0]};
        end
    end

    // State register: a successful push always leads to EXC_SET for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (r_state == ST_EXC_SET) begin
            r_state <= ST_IDLE;
        end else if (w_push) begin
            r_state <= ST_EXC_SET;
        end
    end

endmodule : cpsr_ctrl
`default_nettype wire

// File: tb/tb_cpsr_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_cpsr_ctrl
// Description : Directed self-checking bench for cpsr_ctrl.
// Revision    : 1.0 - initial release
//============================================================================
module tb_cpsr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpsr_q;
    logic [2:0]  cpsr_ld;
    logic [31:0] cpsr_din;
    logic        exc_req;
    logic [5:0]  exc_mode;
    logic        exc_ack;
    logic        exc_ovf;
    logic        ret_req;
    logic        ret_ack;
    logic        ret_err;
    logic        msr_req;
    logic [2:0]  msr_mask;
    logic [31:0] msr_data;
    logic        msr_ack;
    logic        flag_req;
    logic [3:0]  flag_nzcv;
    logic        flag_ack;
    logic [31:0] spsr_q;
    logic [2:0]  spsr_lvl;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cpsr_ctrl #(
        .DEPTH     (4),
        .EXC_IMASK (4'b0011)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpsr_q    (cpsr_q),
        .cpsr_ld   (cpsr_ld),
        .cpsr_din  (cpsr_din),
        .exc_req   (exc_req),
        .exc_mode  (exc_mode),
        .exc_ack   (exc_ack),
        .exc_ovf   (exc_ovf),
        .ret_req   (ret_req),
        .ret_ack   (ret_ack),
        .ret_err   (ret_err),
        .msr_req   (msr_req),
        .msr_mask  (msr_mask),
        .msr_data  (msr_data),
        .msr_ack   (msr_ack),
        .flag_req  (flag_req),
        .flag_nzcv (flag_nzcv),
        .flag_ack  (flag_ack),
        .spsr_q    (spsr_q),
        .spsr_lvl  (spsr_lvl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #2;
    endtask

    task automatic check_acks(input string tag, input logic [3:0] exp);
        check(tag, {28'h0, exc_ack, ret_ack, msr_ack, flag_ack}, {28'h0, exp});
    endtask

    initial begin
        reset     = 1'b1;
        cpsr_q    = 32'h0;
        exc_req   = 1'b0;
        exc_mode  = 6'h0;
        ret_req   = 1'b0;
        msr_req   = 1'b0;
        msr_mask  = 3'b000;
        msr_data  = 32'h0;
        flag_req  = 1'b0;
        flag_nzcv = 4'h0;

        // Reset state
        tick();
        check("rst_ld",   {29'h0, cpsr_ld}, 32'h0);
        check("rst_din",  cpsr_din, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_lvl",  {29'h0, spsr_lvl}, 32'h0);
        check("rst_spsr", spsr_q, 32'h0);
        check("rst_flags", {30'h0, exc_ovf, ret_err}, 32'h0);
        check_acks("rst_acks", 4'b0000);
        reset = 1'b0;
        tick();

        // Flag update
        flag_req = 1'b1; flag_nzcv = 4'b1010; settle();
        check("flag_ld",  {29'h0, cpsr_ld}, 32'h4);
        check("flag_din", cpsr_din, 32'hA000_0000);
        check_acks("flag_ack", 4'b0001);
        tick(); flag_req = 1'b0;

        // Exception entry then return
        cpsr_q = 32'h0000_0010; exc_req = 1'b1; exc_mode = 6'h12; settle();
        check_acks("exc1_c1_ack", 4'b0000);
        check("exc1_c1_ld", {29'h0, cpsr_ld}, 32'h0);
        tick();
        check("exc1_lvl",  {29'h0, spsr_lvl}, 32'h1);
        check("exc1_busy", {31'h0, busy}, 32'h1);
        check("exc1_spsr", spsr_q, 32'h0000_0010);
        check("exc1_ld",   {29'h0, cpsr_ld}, 32'h7);
        check("exc1_din",  cpsr_din, 32'h0000_00D2);
        check_acks("exc1_ack", 4'b1000);
        tick(); exc_req = 1'b0;
        ret_req = 1'b1; settle();
        check("ret1_ld",  {29'h0, cpsr_ld}, 32'h7);
        check("ret1_din", cpsr_din, 32'h0000_0010);
        check_acks("ret1_ack", 4'b0100);
        tick(); ret_req = 1'b0;
        check("ret1_lvl", {29'h0, spsr_lvl}, 32'h0);

        // All four requests at once
        exc_req = 1'b1; ret_req = 1'b1; msr_req = 1'b1; flag_req = 1'b1;
        msr_mask = 3'b010; msr_data = 32'h0000_001F; flag_nzcv = 4'hF; settle();
        check_acks("all_c0", 4'b0000);
        tick();
        check_acks("all_exc", 4'b1000);
        tick(); exc_req = 1'b0; settle();
        check_acks("all_ret", 4'b0100);
        check("all_ret_din", cpsr_din, 32'h0000_0010);
        tick(); ret_req = 1'b0; settle();
        check_acks("all_msr", 4'b0010);
        check("all_msr_ld",  {29'h0, cpsr_ld}, 32'h2);
        check("all_msr_din", cpsr_din, 32'h0000_001F);
        tick(); msr_req = 1'b0; settle();
        check_acks("all_flag", 4'b0001);
        check("all_flag_din", cpsr_din, 32'hF000_0010);
        tick(); flag_req = 1'b0;

        // Fill the stack with four nested exceptions (saved values 1..4)
        for (int i = 1; i <= 4; i++) begin
            cpsr_q = 32'(i); exc_req = 1'b1; exc_mode = 6'h13;
            tick(); tick(); exc_req = 1'b0;
        end
        check("fill_lvl",  {29'h0, spsr_lvl}, 32'h4);
        check("fill_spsr", spsr_q, 32'h4);
        cpsr_q = 32'h5; exc_req = 1'b1; settle();
        check_acks("ovf_ack", 4'b1000);
        check("ovf_flag", {31'h0, exc_ovf}, 32'h1);
        check("ovf_ld",   {29'h0, cpsr_ld}, 32'h0);
        tick(); exc_req = 1'b0;
        check("ovf_lvl",  {29'h0, spsr_lvl}, 32'h4);
        check("ovf_busy", {31'h0, busy}, 32'h0);

        // Unwind in LIFO order
        for (int i = 4; i >= 1; i--) begin
            ret_req = 1'b1; settle();
            check("pop_din", cpsr_din, 32'(i));
            tick(); ret_req = 1'b0;
            check("pop_lvl", {29'h0, spsr_lvl}, 32'(i - 1));
        end

        // Return with an empty stack
        ret_req = 1'b1; settle();
        check_acks("rerr_ack", 4'b0100);
        check("rerr_flag", {31'h0, ret_err}, 32'h1);
        check("rerr_ld",   {29'h0, cpsr_ld}, 32'h0);
        tick(); ret_req = 1'b0;

        // MSR with illegal and legal masks
        msr_req = 1'b1; msr_mask = 3'b011; msr_data = 32'hDEAD_BEEF; settle();
        check_acks("msr_bad_ack", 4'b0010);
        check("msr_bad_ld", {29'h0, cpsr_ld}, 32'h0);
        msr_mask = 3'b001; settle();
        check("msr_ctl_ld",  {29'h0, cpsr_ld}, 32'h1);
        check("msr_ctl_din", cpsr_din, 32'hDEAD_BEEF);
        tick(); msr_req = 1'b0;

        // Reset during EXC_SET aborts the entry
        cpsr_q = 32'h0000_0010; exc_req = 1'b1; exc_mode = 6'h12;
        tick();
        check("abort_busy_pre", {31'h0, busy}, 32'h1);
        reset = 1'b1; settle();
        check_acks("abort_ack", 4'b0000);
        check("abort_lvl",  {29'h0, spsr_lvl}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ld",   {29'h0, cpsr_ld}, 32'h0);
        check("abort_spsr", spsr_q, 32'h0);
        exc_req = 1'b0;
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cpsr_ctrl
`default_nettype wire
